// File: rtl/rvc_asap_5pl_vga_char_wr_if.sv
// ============================================================================
// Module      : rvc_asap_5pl_vga_char_wr_if
// Description : Command, font ROM and VGA write-port bundle for the glyph writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rvc_asap_5pl_vga_char_wr_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [6:0]  req_char;
  logic [6:0]  req_col;
  logic [5:0]  req_row;
  logic        req_fg;
  logic        font_rd;
  logic [9:0]  font_addr;
  logic [7:0]  font_data;
  logic        vga_wr_req;
  logic        vga_wr_gnt;
  logic [31:0] vga_address;
  logic [31:0] vga_data;
  logic [3:0]  vga_byteena;

  // Environment side: issues commands, serves the font ROM, arbitrates writes.
  modport master (
    output req_valid, req_op, req_char, req_col, req_row, req_fg,
    output font_data, vga_wr_gnt,
    input  req_ready, font_rd, font_addr,
    input  vga_wr_req, vga_address, vga_data, vga_byteena
  );

  // Glyph writer side.
  modport slave (
    input  req_valid, req_op, req_char, req_col, req_row, req_fg,
    input  font_data, vga_wr_gnt,
    output req_ready, font_rd, font_addr,
    output vga_wr_req, vga_address, vga_data, vga_byteena
  );
endinterface

`default_nettype wire

// File: rtl/rvc_asap_5pl_vga_char_wr.sv
// ============================================================================
// Module      : rvc_asap_5pl_vga_char_wr
// Description : Packs 8x8 font glyphs into VGA text-cell words, or fills the screen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvc_asap_5pl_vga_char_wr #(
  parameter logic [31:0] VGA_BASE  = 32'h0000_0000,
  parameter int          TEXT_COLS = 80,
  parameter int          TEXT_ROWS = 60
) (
  input  wire logic                    CLK_50,
  input  wire logic                    Reset_N,
  rvc_asap_5pl_vga_char_wr_if.slave    bus,
  output logic                         busy,
  output logic                         err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WR0   = 3'd3;
  localparam logic [2:0] S_WR1   = 3'd4;
  localparam logic [2:0] S_FILL  = 3'd5;

  localparam logic [6:0]  c_cols      = 7'(TEXT_COLS);
  localparam logic [5:0]  c_rows      = 6'(TEXT_ROWS);
  localparam logic [13:0] c_cols14    = 14'(TEXT_COLS);
  localparam logic [13:0] c_fill_last = 14'(TEXT_COLS * 2 * TEXT_ROWS - 1);

  logic [2:0]  r_state;
  logic [6:0]  r_char;
  logic [6:0]  r_col;
  logic [5:0]  r_row;
  logic        r_fg;
  logic [2:0]  r_k;
  logic        r_cap_en;
  logic [2:0]  r_cap_k;
  logic [63:0] r_glyph;
  logic [13:0] r_fill;
  logic        r_err;

  logic        w_idle;
  logic        w_in_range;
  logic [7:0]  w_glyph_byte;
  logic [13:0] w_w0;
  logic [13:0] w_w1;
  logic [13:0] w_word;
  logic [31:0] w_data;

  assign w_idle     = (r_state == S_IDLE);
  assign w_in_range = (bus.req_col < c_cols) && (bus.req_row < c_rows);

  // Font bit7 is the leftmost pixel but memory bit0 is, so reverse, then polarity.
  always_comb begin
    w_glyph_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_glyph_byte[i] = bus.font_data[7-i];
    end
    w_glyph_byte = w_glyph_byte ^ {8{~r_fg}};
  end

  assign w_w0 = {7'd0, r_row, 1'b0} * c_cols14 + {7'd0, r_col};
  assign w_w1 = w_w0 + c_cols14;

  always_ff @(posedge CLK_50 or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state  <= S_IDLE;
      r_char   <= 7'd0;
      r_col    <= 7'd0;
      r_row    <= 6'd0;
      r_fg     <= 1'b0;
      r_k      <= 3'd0;
      r_cap_en <= 1'b0;
      r_cap_k  <= 3'd0;
      r_glyph  <= 64'd0;
      r_fill   <= 14'd0;
      r_err    <= 1'b0;
    end else begin
      r_err    <= 1'b0;
      // ROM data lags the read strobe by one cycle, so the capture slot trails r_k.
      r_cap_en <= (r_state == S_FETCH);
      r_cap_k  <= r_k;
      if (r_cap_en) begin
        r_glyph[{r_cap_k, 3'b000} +: 8] <= w_glyph_byte;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_char <= bus.req_char;
            r_col  <= bus.req_col;
            r_row  <= bus.req_row;
            r_fg   <= bus.req_fg;
            if (bus.req_op) begin
              r_fill  <= 14'd0;
              r_state <= S_FILL;
            end else if (w_in_range) begin
              r_k     <= 3'd0;
              r_state <= S_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_state <= S_WR0;
        end
        S_WR0: begin
          if (bus.vga_wr_gnt) begin
            r_state <= S_WR1;
          end
        end
        S_WR1: begin
          if (bus.vga_wr_gnt) begin
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          if (bus.vga_wr_gnt) begin
            if (r_fill == c_fill_last) begin
              r_state <= S_IDLE;
            end else begin
              r_fill <= r_fill + 14'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_word = 14'd0;
    w_data = 32'd0;
    case (r_state)
      S_WR0: begin
        w_word = w_w0;
        w_data = r_glyph[31:0];
      end
      S_WR1: begin
        w_word = w_w1;
        w_data = r_glyph[63:32];
      end
      S_FILL: begin
        w_word = r_fill;
        w_data = {32{~r_fg}};
      end
      default: begin
        w_word = 14'd0;
        w_data = 32'd0;
      end
    endcase
  end

  assign bus.req_ready   = w_idle;
  assign busy            = ~w_idle;
  assign err             = r_err;
  assign bus.font_rd     = (r_state == S_FETCH);
  assign bus.font_addr   = bus.font_rd ? {r_char, r_k} : 10'd0;
  assign bus.vga_wr_req  = (r_state == S_WR0) || (r_state == S_WR1) || (r_state == S_FILL);
  assign bus.vga_address = bus.vga_wr_req ? (VGA_BASE + {16'd0, w_word, 2'b00}) : 32'd0;
  assign bus.vga_data    = bus.vga_wr_req ? w_data : 32'd0;
  assign bus.vga_byteena = bus.vga_wr_req ? 4'hF : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_rvc_asap_5pl_vga_char_wr.sv
// ============================================================================
// Module      : tb_rvc_asap_5pl_vga_char_wr
// Description : Self-checking bench for the VGA glyph writer against a write-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rvc_asap_5pl_vga_char_wr;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 60;

  logic CLK_50  = 1'b0;
  logic Reset_N = 1'b0;
  logic busy;
  logic err;

  rvc_asap_5pl_vga_char_wr_if bus();

  rvc_asap_5pl_vga_char_wr #(
    .VGA_BASE  (32'h0000_0000),
    .TEXT_COLS (TEXT_COLS),
    .TEXT_ROWS (TEXT_ROWS)
  ) dut (
    .CLK_50  (CLK_50),
    .Reset_N (Reset_N),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  always #5 CLK_50 = ~CLK_50;

  // Font ROM: data is valid the cycle after the strobe, garbage otherwise.
  logic [7:0] rom [0:1023];
  always @(posedge CLK_50) begin
    bus.font_data <= bus.font_rd ? rom[bus.font_addr] : 8'($urandom);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc      = 0;
  bit gnt_rand = 0;

  // Inputs change just after posedge, so a negedge sample sees what the next edge accepts.
  always @(negedge CLK_50) begin
    if (Reset_N && bus.vga_wr_req && bus.vga_wr_gnt) begin
      obs_q.push_back('{a: bus.vga_address, d: bus.vga_data, c: cyc});
    end
  end

  task automatic step();
    @(posedge CLK_50);
    #1;
    cyc++;
    if (gnt_rand) bus.vga_wr_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gbyte(input logic [7:0] row, input logic fg);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = row[7-i];
    return r ^ {8{~fg}};
  endfunction

  task automatic expect_glyph(input logic [6:0] ch, input int col, input int row,
                              input logic fg, input int c0);
    logic [31:0] d0;
    logic [31:0] d1;
    int          w0;
    for (int k = 0; k < 4; k++) begin
      d0[8*k +: 8] = gbyte(rom[{ch, 3'(k)}], fg);
      d1[8*k +: 8] = gbyte(rom[{ch, 3'(k + 4)}], fg);
    end
    w0 = 2 * row * TEXT_COLS + col;
    exp_q.push_back('{a: 32'(4 * w0), d: d0, c: c0});
    exp_q.push_back('{a: 32'(4 * (w0 + TEXT_COLS)), d: d1, c: (c0 < 0) ? -1 : c0 + 1});
  endtask

  task automatic send(input logic op, input logic [6:0] ch, input logic [6:0] col,
                      input logic [5:0] row, input logic fg);
    chk("ready_before_cmd", 64'(bus.req_ready), 64'd1);
    bus.req_op    = op;
    bus.req_char  = ch;
    bus.req_col   = col;
    bus.req_row   = row;
    bus.req_fg    = fg;
    bus.req_valid = 1'b1;
    step();
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 64'(obs_q[i].a), 64'(exp_q[i].a));
      chk({tag, "_data"}, 64'(obs_q[i].d), 64'(exp_q[i].d));
      if (exp_q[i].c >= 0) chk({tag, "_cycle"}, 64'(obs_q[i].c), 64'(exp_q[i].c));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] a_rows [8];
    int         bad;

    a_rows = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      rom[10'h208 + k] = a_rows[k];
      rom[{7'h20, 3'(k)}] = 8'h00;
    end
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_char   = 7'd0;
    bus.req_col    = 7'd0;
    bus.req_row    = 6'd0;
    bus.req_fg     = 1'b0;
    bus.vga_wr_gnt = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK_50);
    #1;
    chk("rst_ready",   64'(bus.req_ready),   64'd1);
    chk("rst_busy",    64'(busy),            64'd0);
    chk("rst_wr_req",  64'(bus.vga_wr_req),  64'd0);
    chk("rst_font_rd", 64'(bus.font_rd),     64'd0);
    chk("rst_err",     64'(err),             64'd0);
    chk("rst_addr",    64'(bus.vga_address), 64'd0);
    chk("rst_byteena", 64'(bus.vga_byteena), 64'd0);
    Reset_N = 1'b1;
    step();

    // Directed glyph 'A' at the origin with free-running grants
    bus.vga_wr_gnt = 1'b1;
    send(1'b0, 7'h41, 7'd0, 6'd0, 1'b1);
    expect_glyph(7'h41, 0, 0, 1'b1, acc + 9);
    for (int k = 0; k < 8; k++) begin
      chk("a_font_rd",   64'(bus.font_rd),   64'd1);
      chk("a_font_addr", 64'(bus.font_addr), 64'(10'h208 + k));
      step();
    end
    chk("a_capt_no_rd", 64'(bus.font_rd), 64'd0);
    step();
    chk("a_wr0_req",  64'(bus.vga_wr_req),  64'd1);
    chk("a_wr0_be",   64'(bus.vga_byteena), 64'hF);
    chk("a_wr0_addr", 64'(bus.vga_address), 64'd0);
    chk("a_wr0_data", 64'(bus.vga_data),    64'h6666_3C18);
    step();
    chk("a_wr1_addr", 64'(bus.vga_address), 64'd320);
    chk("a_wr1_data", 64'(bus.vga_data),    64'h0066_667E);
    chk("a_wr1_ready", 64'(bus.req_ready),  64'd0);
    step();
    chk("a_ready_c12", 64'(bus.req_ready),  64'd1);
    compare_writes("glyph_a");

    // Bottom-right corner, inverted blank glyph
    send(1'b0, 7'h20, 7'd79, 6'd59, 1'b0);
    exp_q.push_back('{a: 32'd38076, d: 32'hFFFF_FFFF, c: acc + 9});
    exp_q.push_back('{a: 32'd38396, d: 32'hFFFF_FFFF, c: acc + 10});
    wait_idle(40);
    compare_writes("corner");

    // Grant stall in WR0
    bus.vga_wr_gnt = 1'b0;
    send(1'b0, 7'h33, 7'd5, 6'd3, 1'b1);
    expect_glyph(7'h33, 5, 3, 1'b1, acc + 14);
    repeat (9) step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  64'(bus.vga_wr_req),  64'd1);
      chk("stall_addr", 64'(bus.vga_address), 64'(exp_q[0].a));
      chk("stall_data", 64'(bus.vga_data),    64'(exp_q[0].d));
      step();
    end
    bus.vga_wr_gnt = 1'b1;
    step();
    chk("stall_wr1_addr",  64'(bus.vga_address), 64'(exp_q[1].a));
    chk("stall_wr1_ready", 64'(bus.req_ready),   64'd0);
    step();
    chk("stall_ready", 64'(bus.req_ready), 64'd1);
    compare_writes("stall");

    // Out-of-range commands are dropped with an error pulse
    send(1'b0, 7'h41, 7'd80, 6'd0, 1'b1);
    chk("oor_col_err",   64'(err),            64'd1);
    chk("oor_col_ready", 64'(bus.req_ready),  64'd1);
    chk("oor_col_rd",    64'(bus.font_rd),    64'd0);
    chk("oor_col_wr",    64'(bus.vga_wr_req), 64'd0);
    step();
    chk("oor_err_pulse", 64'(err), 64'd0);
    send(1'b0, 7'h41, 7'd0, 6'd60, 1'b1);
    chk("oor_row_err", 64'(err), 64'd1);
    repeat (4) step();
    chk("oor_no_font", 64'(bus.font_rd), 64'd0);
    compare_writes("oor");

    // Asynchronous reset in the middle of a stalled WR0
    bus.vga_wr_gnt = 1'b0;
    send(1'b0, 7'h12, 7'd10, 6'd10, 1'b1);
    repeat (9) step();
    chk("rstwr_req_before", 64'(bus.vga_wr_req), 64'd1);
    #2;
    Reset_N = 1'b0;
    #1;
    chk("rstwr_req",   64'(bus.vga_wr_req), 64'd0);
    chk("rstwr_ready", 64'(bus.req_ready),  64'd1);
    chk("rstwr_busy",  64'(busy),           64'd0);
    step();
    Reset_N = 1'b1;
    bus.vga_wr_gnt = 1'b1;
    repeat (20) step();
    chk("rstwr_ready_after", 64'(bus.req_ready), 64'd1);
    compare_writes("rstwr");

    // Random in-range glyphs under random grants
    gnt_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [6:0] ch;
      logic [6:0] col;
      logic [5:0] row;
      logic       fg;
      ch  = 7'($urandom);
      col = 7'($urandom_range(0, TEXT_COLS - 1));
      row = 6'($urandom_range(0, TEXT_ROWS - 1));
      fg  = 1'($urandom);
      send(1'b0, ch, col, row, fg);
      expect_glyph(ch, int'(col), int'(row), fg, -1);
      wait_idle(300);
      compare_writes("rand_glyph");
    end

    // Clear screen under random grants
    send(1'b1, 7'd0, 7'd0, 6'd0, 1'b1);
    wait_idle(60000);
    gnt_rand = 1'b0;
    chk("fill_count", 64'(obs_q.size()), 64'(TEXT_COLS * 2 * TEXT_ROWS));
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].a !== 32'(4 * i) || obs_q[i].d !== 32'd0) bad++;
    end
    chk("fill_bad_entries", 64'(bad), 64'd0);
    if (obs_q.size() > 0)
      chk("fill_last_addr", 64'(obs_q[obs_q.size() - 1].a), 64'd38396);
    step();
    chk("fill_ready", 64'(bus.req_ready),  64'd1);
    chk("fill_no_wr", 64'(bus.vga_wr_req), 64'd0);
    obs_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
